blk_grid_buffer: RTL and testbench
==================================

Name: blk_grid_buffer

Overview:
- Two-dimensional successor to the per-line dark/light block classifier.
- Tiles the active frame into KH x KV pixel blocks and counts "bright" pixels per block (wd_i >= LUMA_TH).
- At the end of each block row, commits a per-block dark/light decision with hysteresis into a BLKS_H x BLKS_V decision array.
- Replays the stored decision for the block under the current pixel on rx_o during the next frame; sits between the video timing front-end and the pixel inverter.

Parameters:
- HP, 1920, active pixels per line.
- VP, 1080, active lines per frame.
- KH, 10, block width in pixels.
- KV, 10, block height in lines.
- LUMA_TH, 128, 8-bit luma threshold; a pixel is bright when wd_i >= LUMA_TH.
- TH_HI, KH*KV/2, bright-pixel count at or above which a light block becomes dark-inverted (rx_o=1).
- TH_LO, KH*KV/4, bright-pixel count below which a dark-inverted block returns to light (rx_o=0). Requires TH_LO <= TH_HI.

Derived values:
- BLKS_H = HP/KH, BLKS_V = VP/KV (integer division).
- CW = $clog2(KH*KV+1).

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous active-low reset
- freeze_i  in  1  when high, decisions are not updated for the frame
- vs_i  in  1  vertical sync, active high
- hs_i  in  1  horizontal sync, active high
- de_i  in  1  data enable
- wd_i  in  8  pixel luma
- rx_o  out  1  registered invert decision for the current pixel's block

Behaviour:
Reset (rst_ni low, async, applies immediately):
- All counters, accumulators and the decision array clear to 0.
- rx_o = 0; freeze latch = 0.
- Reset mid-frame: after release, the block waits for the next vs_i rising edge before accumulating. Until then, rx_o = 0.

Timing tracking:
- vs_i rising edge clears v_cur, vb_cur and all accumulators, and latches frz <= freeze_i for the whole frame.
- Within a line, h_cur counts 0..KH-1 on de_i and increments hb_cur on wrap (same scheme as the 1-D block).
- A de_i falling edge clears h_cur and hb_cur and increments v_cur. When v_cur reaches KV-1 it wraps to 0, vb_cur increments, and a commit is triggered.
- hs_i is used only for sanity; no state changes on it.

Accumulation:
- On each de_i cycle with hb_cur < BLKS_H and vb_cur < BLKS_V, acc[hb_cur] += (wd_i >= LUMA_TH).
- Each accumulator is CW bits and saturates at 2^CW-1.
- Pixels beyond BLKS_H*KH in a line, and lines beyond BLKS_V*KV in a frame, are ignored.

Commit (cycle after the KV-th de_i falling edge of a block row):
- For every column c: prev = dec[vb][c].
  - If prev = 0, new = (acc[c] >= TH_HI).
  - If prev = 1, new = ~(acc[c] < TH_LO).
- If frz = 0, write new; if frz = 1, dec is unchanged.
- All acc[c] clear in the same cycle. A de_i arriving in the commit cycle accumulates into the cleared value (clear has priority, then add).
- A partial block row (vs_i before KV lines complete) is discarded without commit.

Output:
- rx_o <= de_i && in-range ? dec[vb_cur][hb_cur] : 0. Latency is one clk_i after the pixel.
- rx_o reflects the previous frame's committed decision for the same block. The current-row commit happens after that row is fully displayed, so there is no tearing.

Simultaneous events:
- vs_i rising edge coincident with a commit: the commit completes first, then counters clear.

Optional Feature:
- Macro BLK_GRID_HYST_EN.
- Defined: hysteresis as above, using TH_HI and TH_LO.
- Undefined: TH_LO is unused and new = (acc[c] >= TH_HI) regardless of prev. The decision array is still needed for replay.

Test Plan:
Common bench configuration: HP=40, VP=4, KH=10, KV=2, LUMA_TH=128, TH_HI=10, TH_LO=5, giving BLKS_H=4 and BLKS_V=2.
1. Frame 1 all wd_i=200 -> rx_o=0 throughout frame 1; frame 2 rx_o=1 on every de_i cycle, one cycle after the pixel.
2. Hysteresis: block (0,0) state dark. Next frame has 7 bright pixels -> stays dark. Then 4 bright pixels -> light. Then 9 bright pixels -> stays light. Then 10 -> dark. Without BLK_GRID_HYST_EN, the 7-bright frame gives light.
3. freeze_i=1 sampled at a vs_i edge, with content changing from bright to dark -> rx_o in the following frame still shows the pre-freeze decisions. freeze_i toggling mid-frame has no effect.
4. Lines of 45 pixels and a frame of 5 lines -> pixels 40-44 and line 4 yield rx_o=0 and do not alter acc or dec.
5. rst_ni pulsed low mid-line in frame 2 -> rx_o=0 immediately. Frame 3 after the next vs_i shows rx_o=0 everywhere because the array was cleared.
6. vs_i after only 1 line of a block row -> no commit; that row's dec is unchanged from the previous frame.

Source files
------------

// File: rtl/blk_grid_buffer.sv
// Tiles the frame into KH x KV blocks, counts bright pixels per block and commits a dark/light
// decision per block row; replays it on rx_o next frame. Macro BLK_GRID_HYST_EN enables hysteresis.
module blk_grid_buffer #(
    parameter int HP      = 1920,
    parameter int VP      = 1080,
    parameter int KH      = 10,
    parameter int KV      = 10,
    parameter int LUMA_TH = 128,
    parameter int TH_HI   = KH * KV / 2,
    parameter int TH_LO   = KH * KV / 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       freeze_i,
    input  logic       vs_i,
    input  logic       hs_i,
    input  logic       de_i,
    input  logic [7:0] wd_i,
    output logic       rx_o
);
    localparam int BLKS_H = HP / KH;
    localparam int BLKS_V = VP / KV;
    localparam int CW     = $clog2(KH * KV + 1);
    localparam int HW     = (KH > 1) ? $clog2(KH) : 1;
    localparam int VW     = (KV > 1) ? $clog2(KV) : 1;
    localparam int HBW    = $clog2(BLKS_H + 1);
    localparam int VBW    = $clog2(BLKS_V + 1);
    localparam int HIW    = (BLKS_H > 1) ? $clog2(BLKS_H) : 1;
    localparam int VIW    = (BLKS_V > 1) ? $clog2(BLKS_V) : 1;

    localparam logic [HW-1:0]  KH_LAST = HW'(KH - 1);
    localparam logic [VW-1:0]  KV_LAST = VW'(KV - 1);
    localparam logic [HBW-1:0] HB_END  = HBW'(BLKS_H);
    localparam logic [VBW-1:0] VB_END  = VBW'(BLKS_V);
    localparam logic [CW-1:0]  TH_HI_C = CW'(TH_HI);
    localparam logic [CW-1:0]  TH_LO_C = CW'(TH_LO);
    localparam logic [CW-1:0]  ACC_MAX = {CW{1'b1}};
    localparam logic [7:0]     LUMA_C  = 8'(LUMA_TH);

    logic           vs_p1, de_p1;
    logic           armed, frz;
    logic [HW-1:0]  h_cur;
    logic [HBW-1:0] hb_cur;
    logic [VW-1:0]  v_cur;
    logic [VBW-1:0] vb_cur;
    logic           commit_vld_p1;
    logic [VIW-1:0] commit_row_p1;

    logic [CW-1:0]     acc [BLKS_H];
    logic [BLKS_H-1:0] dec [BLKS_V];
    logic [BLKS_H-1:0] dec_new;

    logic           vs_rise, bright, in_rng, pix_vld;
    logic [HIW-1:0] hb_idx;
    logic [VIW-1:0] vb_idx;
    logic           unused_ok;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic inc);
        if (inc && (a != ACC_MAX)) return a + CW'(1);
        return a;
    endfunction

    function automatic logic next_dec(input logic prev, input logic [CW-1:0] cnt);
`ifdef BLK_GRID_HYST_EN
        return prev ? !(cnt < TH_LO_C) : (cnt >= TH_HI_C);
`else
        logic unused_prev;
        unused_prev = prev;
        return cnt >= TH_HI_C;
`endif
    endfunction

    assign vs_rise = vs_i && !vs_p1;
    assign bright  = wd_i >= LUMA_C;
    assign hb_idx  = hb_cur[HIW-1:0];
    assign vb_idx  = vb_cur[VIW-1:0];
    // Nothing accumulates or replays until a vs edge has been seen after reset.
    assign in_rng  = armed && (hb_cur < HB_END) && (vb_cur < VB_END);
    assign pix_vld = de_i && in_rng;
    assign unused_ok = &{1'b0, hs_i, TH_LO_C};

    always_comb begin
        dec_new = '0;
        for (int c = 0; c < BLKS_H; c++) begin
            dec_new[c] = next_dec(dec[commit_row_p1][c], acc[c]);
        end
    end

    // Stage p0 -> p1: sync edge detection, block position tracking, commit request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_p1         <= 1'b0;
            de_p1         <= 1'b0;
            armed         <= 1'b0;
            frz           <= 1'b0;
            h_cur         <= '0;
            hb_cur        <= '0;
            v_cur         <= '0;
            vb_cur        <= '0;
            commit_vld_p1 <= 1'b0;
            commit_row_p1 <= '0;
        end else begin
            vs_p1         <= vs_i;
            de_p1         <= de_i;
            commit_vld_p1 <= 1'b0;
            if (vs_rise) begin
                armed  <= 1'b1;
                frz    <= freeze_i;
                h_cur  <= '0;
                hb_cur <= '0;
                v_cur  <= '0;
                vb_cur <= '0;
            end else if (armed) begin
                if (de_i) begin
                    if (h_cur == KH_LAST) begin
                        h_cur <= '0;
                        if (hb_cur != HB_END) hb_cur <= hb_cur + HBW'(1);
                    end else begin
                        h_cur <= h_cur + HW'(1);
                    end
                end else if (de_p1) begin
                    h_cur  <= '0;
                    hb_cur <= '0;
                    if (v_cur == KV_LAST) begin
                        v_cur <= '0;
                        if (vb_cur != VB_END) begin
                            vb_cur        <= vb_cur + VBW'(1);
                            commit_vld_p1 <= 1'b1;
                            commit_row_p1 <= vb_idx;
                        end
                    end else begin
                        v_cur <= v_cur + VW'(1);
                    end
                end
            end
        end
    end

    // Stage p1: accumulate, commit decisions, replay
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < BLKS_H; c++) acc[c] <= '0;
            for (int r = 0; r < BLKS_V; r++) dec[r] <= '0;
            rx_o <= 1'b0;
        end else begin
            // A commit coincident with vs still lands: it reads frz and acc before they change.
            if (commit_vld_p1 && !frz) dec[commit_row_p1] <= dec_new;
            for (int c = 0; c < BLKS_H; c++) begin
                if (vs_rise) begin
                    acc[c] <= '0;
                end else if (commit_vld_p1) begin
                    acc[c] <= (pix_vld && (hb_idx == HIW'(c))) ? sat_add('0, bright) : '0;
                end else if (pix_vld && (hb_idx == HIW'(c))) begin
                    acc[c] <= sat_add(acc[c], bright);
                end
            end
            rx_o <= pix_vld ? dec[vb_idx][hb_idx] : 1'b0;
        end
    end
endmodule

// File: tb/tb_blk_grid_buffer.sv
// Randomized bench for blk_grid_buffer: frame-level reference model of block counts and decisions.
module tb_blk_grid_buffer;
    localparam int HP = 40, VP = 4, KH = 10, KV = 2, LUMA_TH = 128, TH_HI = 10, TH_LO = 5;
    localparam int BH = HP / KH, BV = VP / KV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       freeze = 1'b0, vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [7:0] wd = 8'd0;
    logic       rx;

    int errors = 0, checks = 0, fno = 0;
    bit mdec [BV][BH];
    bit marmed = 1'b0, mfrz = 1'b0;
    logic [7:0] pix [8][64];

    always #5 clk = ~clk;

    blk_grid_buffer #(.HP(HP), .VP(VP), .KH(KH), .KV(KV), .LUMA_TH(LUMA_TH),
                      .TH_HI(TH_HI), .TH_LO(TH_LO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze), .vs_i(vs), .hs_i(hs),
        .de_i(de), .wd_i(wd), .rx_o(rx)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: rx_o=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic d, input logic [7:0] w,
                        input logic f, input logic exp, input string tag);
        @(negedge clk);
        vs = v; hs = h; de = d; wd = w;
        freeze = v ? f : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1 check(tag, rx, exp);
    endtask

    // mode 0 random, 1 all bright, 2 all dark, 3 random with exactly n bright in block (0,0)
    task automatic gen_frame(input int mode, input int n);
        for (int l = 0; l < 8; l++) begin
            for (int p = 0; p < 64; p++) begin
                case (mode)
                    1: pix[l][p] = 8'd200;
                    2: pix[l][p] = 8'($urandom_range(0, 127));
                    default: pix[l][p] = ($urandom_range(0, 3) == 0) ? 8'(127 + $urandom_range(0, 1))
                                                                   : 8'($urandom_range(0, 255));
                endcase
                if (mode == 3 && l < KV && p < KH)
                    pix[l][p] = (l * KH + p < n) ? 8'd200 : 8'($urandom_range(0, 127));
                if (p >= HP || l >= VP) pix[l][p] = 8'd200;
            end
        end
    endtask

    task automatic reset_pulse(input logic [7:0] w);
        @(negedge clk);
        vs = 1'b0; hs = 1'b0; de = 1'b1; wd = w;
        #2 rst_n = 1'b0;
        #1 check("rst_async", rx, 1'b0);
        for (int r = 0; r < BV; r++) for (int c = 0; c < BH; c++) mdec[r][c] = 1'b0;
        marmed = 1'b0;
        @(posedge clk);
        #1 check("rst_hold", rx, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int nl, input int np, input bit do_vs, input bit frz,
                             input int rst_l, input int rst_p);
        logic e;
        int   cnt;
        bit   nv;
        fno++;
        if (do_vs) begin
            step(1'b1, 1'b0, 1'b0, 8'd0, frz, 1'b0, "vs");
            step(1'b1, 1'b0, 1'b0, 8'd0, frz, 1'b0, "vs");
            marmed = 1'b1;
            mfrz   = frz;
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "vbp");
        for (int l = 0; l < nl; l++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "hs");
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "hbp");
            for (int p = 0; p < np; p++) begin
                e = (marmed && p < BH * KH && l < BV * KV) ? mdec[l / KV][p / KH] : 1'b0;
                if (l == rst_l && p == rst_p) reset_pulse(pix[l][p]);
                else step(1'b0, 1'b0, 1'b1, pix[l][p], 1'b0, e,
                          $sformatf("f%0d l%0d p%0d", fno, l, p));
            end
            repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "hfp");
        end
        // Only complete, in-range block rows of an armed frame produce new decisions.
        if (marmed) begin
            for (int r = 0; r < BV; r++) begin
                if ((r + 1) * KV <= nl) begin
                    for (int c = 0; c < BH; c++) begin
                        cnt = 0;
                        for (int l = r * KV; l < (r + 1) * KV; l++)
                            for (int p = c * KH; p < (c + 1) * KH; p++)
                                if (pix[l][p] >= LUMA_TH) cnt++;
`ifdef BLK_GRID_HYST_EN
                        nv = (mdec[r][c] == 1'b0) ? (cnt >= TH_HI) : !(cnt < TH_LO);
`else
                        nv = (cnt >= TH_HI);
`endif
                        if (!mfrz) mdec[r][c] = nv;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int r = 0; r < BV; r++) for (int c = 0; c < BH; c++) mdec[r][c] = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_rx", rx, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // No vs seen yet after reset: nothing replays or accumulates
        gen_frame(1, 0); run_frame(VP, HP, 1'b0, 1'b0, -1, -1);

        // All-bright frames: dark everywhere only from the second frame on
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);

        // Hysteresis sequence on block (0,0): 7, 4, 9, 10 bright pixels
        gen_frame(3, 7);  run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(3, 4);  run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(3, 9);  run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(3, 10); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(0, 0);  run_frame(VP, HP, 1'b1, 1'b0, -1, -1);

        // Freeze latched at vs holds pre-freeze decisions
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(2, 0); run_frame(VP, HP, 1'b1, 1'b1, -1, -1);
        gen_frame(2, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(0, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);

        // Over-long lines and an extra line are ignored
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(2, 0); run_frame(VP + 1, HP + 5, 1'b1, 1'b0, -1, -1);
        gen_frame(0, 0); run_frame(VP + 1, HP + 5, 1'b1, 1'b0, -1, -1);

        // Partial block row is discarded
        gen_frame(2, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(1, 0); run_frame(KV + 1, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(2, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);

        // Mid-line reset clears rx_o at once and the whole decision array
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, 1, 15);
        gen_frame(1, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);
        gen_frame(0, 0); run_frame(VP, HP, 1'b1, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
